// File: rtl/resc_stream_counter_if.sv
// Stream-to-binary handshake bundle for the ReSC output stage: stream bits and
// start on one side, converted result plus done/busy status on the other.
interface resc_stream_counter_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] y_bin;
  logic             done;
  logic             busy;

  modport master (
    output start, bit_in, bit_valid,
    input  y_bin, done, busy
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output y_bin, done, busy
  );
endinterface

// File: rtl/resc_stream_counter.sv
// Counts ones over a LENGTH-bit stochastic stream window and presents the
// saturated count on y_bin, with a start/done handshake around each window.
module resc_stream_counter #(
  parameter int WIDTH  = 10,
  parameter int LENGTH = 1024
) (
  input logic                  clk,
  input logic                  reset,
  resc_stream_counter_if.slave stream
);

  localparam int ACC_W = $clog2(LENGTH + 1);
  localparam int CMP_W = ((ACC_W > WIDTH) ? ACC_W : WIDTH) + 1;
  localparam logic [CMP_W-1:0] FULL_SCALE = CMP_W'({WIDTH{1'b1}});
  localparam logic [ACC_W-1:0] LAST_IDX   = ACC_W'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc, samples;
  logic [CMP_W-1:0]   final_sum;
  logic [WIDTH-1:0]   y_next;
  logic               accept_start;
  logic               take_bit;
  logic               last_bit;

  assign accept_start = (state_q != COUNT) && stream.start;
  assign take_bit     = (state_q == COUNT) && stream.bit_valid;
  assign last_bit     = take_bit && (samples == LAST_IDX);

  // The closing bit is folded in before clamping, so a full window of ones
  // at LENGTH = 2^WIDTH lands on full scale instead of wrapping to zero.
  assign final_sum = CMP_W'(acc) + CMP_W'(stream.bit_in);
  assign y_next    = (final_sum > FULL_SCALE) ? {WIDTH{1'b1}} : final_sum[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (stream.start) state_d = COUNT;
      COUNT:   if (last_bit)     state_d = DONE;
      DONE:    state_d = stream.start ? COUNT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      samples      <= '0;
      stream.y_bin <= '0;
    end else begin
      if (accept_start) begin
        acc     <= '0;
        samples <= '0;
      end else if (take_bit) begin
        acc     <= acc + ACC_W'(stream.bit_in);
        samples <= samples + 1'b1;
      end
      if (last_bit) stream.y_bin <= y_next;
    end
  end

  assign stream.busy = (state_q == COUNT);
  assign stream.done = (state_q == DONE);

endmodule

// File: tb/tb_resc_stream_counter.sv
// Directed bench for resc_stream_counter: a window-level reference model is
// compared against the DUT every cycle, plus literal results per conversion.
module tb_resc_stream_counter;

  localparam int WIDTH  = 10;
  localparam int LENGTH = 1024;
  localparam int MAXV   = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;

  resc_stream_counter_if #(.WIDTH(WIDTH)) bus ();

  resc_stream_counter #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .stream (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a conversion is "accepted start, then LENGTH valid bits";
  // result is the number of ones among them, clamped to full scale.
  int m_phase;   // 0 idle, 1 collecting, 2 result cycle
  int m_ones;
  int m_seen;
  int m_y;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_ones = 0; m_seen = 0; m_y = 0;
    end else if (m_phase == 1) begin
      if (bus.bit_valid) begin
        m_ones += int'(bus.bit_in);
        m_seen += 1;
        if (m_seen == LENGTH) begin
          m_y     = (m_ones > MAXV) ? MAXV : m_ones;
          m_phase = 2;
        end
      end
    end else if (bus.start) begin
      m_phase = 1; m_ones = 0; m_seen = 0;
    end else begin
      m_phase = 0;
    end
  end

  int cyc = 0;
  int done_count = 0;
  int done_cyc[$];

  always @(negedge clk) begin
    cyc++;
    check("y_bin_vs_model", int'(bus.y_bin), m_y);
    check("done_vs_model",  int'(bus.done),  int'(m_phase == 2));
    check("busy_vs_model",  int'(bus.busy),  int'(m_phase == 1));
    if (bus.done) begin
      done_count++;
      done_cyc.push_back(cyc);
    end
  end

  // Exactly k ones spread evenly across a window of LENGTH valid bits.
  function automatic logic spread(input int k, input int i);
    return 1'((((i + 1) * k) / LENGTH) - ((i * k) / LENGTH));
  endfunction

  task automatic conv(input int k, input bit stall, input bit extra,
                      input int abort_at, input int hold, input int exp_y);
    int idx = 0;
    int n = 0;
    int d0;
    bit v;
    d0 = done_count;
    bus.start = 1'b1; bus.bit_in = 1'b1; bus.bit_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (idx < LENGTH) begin
      v = !(stall && (n % 3 == 2));
      bus.bit_valid = v;
      bus.bit_in    = v ? spread(k, idx) : 1'($urandom);
      bus.start     = extra && (n == 100 || n == 700);
      if (hold >= 0 && idx == 500) check("y_held_prev", int'(bus.y_bin), hold);
      if (abort_at >= 0 && idx == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check("abort_y_bin", int'(bus.y_bin), 0);
        check("abort_busy",  int'(bus.busy),  0);
        check("abort_done",  int'(bus.done),  0);
        @(negedge clk);
        reset = 1'b0; bus.bit_valid = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check("abort_no_done", done_count, d0);
        return;
      end
      @(posedge clk); #1;
      if (v) idx++;
      n++;
    end
    bus.bit_valid = 1'b0; bus.start = 1'b0; bus.bit_in = 1'b0;
    check("done_high", int'(bus.done), 1);
    check("y_literal", int'(bus.y_bin), exp_y);
    check("model_literal", m_y, exp_y);
    @(posedge clk); #1;
    check("busy_after", int'(bus.busy), 0);
    check("done_after", int'(bus.done), 0);
    check("one_done_pulse", done_count, d0 + 1);
  endtask

  task automatic back_to_back(input int k0, input int k1);
    int k;
    bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++) begin
      k = (w == 0) ? k0 : k1;
      for (int i = 0; i < LENGTH; i++) begin
        bus.bit_valid = 1'b1;
        bus.bit_in    = spread(k, i);
        @(posedge clk); #1;
      end
      check("b2b_done", int'(bus.done), 1);
      check("b2b_y", int'(bus.y_bin), k);
      bus.bit_valid = 1'b1; bus.bit_in = 1'b1;   // ignored in the DONE cycle
      if (w == 1) bus.start = 1'b0;
      @(posedge clk); #1;
      check("b2b_busy_next", int'(bus.busy), (w == 0) ? 1 : 0);
    end
    bus.bit_valid = 1'b0;
    check("b2b_done_period", done_cyc[$] - done_cyc[$-1], LENGTH + 1);
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_y_bin", int'(bus.y_bin), 0);
    check("reset_done",  int'(bus.done),  0);
    check("reset_busy",  int'(bus.busy),  0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    conv(0,    1'b0, 1'b0, -1, -1,  0);
    conv(1024, 1'b0, 1'b0, -1, -1,  MAXV);
    conv(512,  1'b0, 1'b0, -1, -1,  512);
    conv(549,  1'b0, 1'b0, -1, 512, 549);
    conv(300,  1'b1, 1'b1, -1, -1,  300);
    conv(1024, 1'b0, 1'b0, 500, -1, 0);
    check("y_after_abort", int'(bus.y_bin), 0);
    conv(1024, 1'b0, 1'b0, -1, -1,  MAXV);
    back_to_back(100, 900);
    repeat (3) @(posedge clk);
    #1;
    check("final_y_hold", int'(bus.y_bin), 900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
